// File: rtl/stack_seq_ctrl.sv
// Decode-stage sequencer for CALL/RET/RTI/interrupt stack ops; optional INT_MASK_EN adds int_mask.
// Latency: start at E0, stack ops E1(..E2), then FLUSH_CYCLES flush cycles. Backpressure: stall_in freezes state, masks actions.
// Outputs decode combinationally from registered state; stall is also raised in the IDLE start cycle.
module stack_seq_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic call_req,
  input  logic ret_req,
  input  logic rti_req,
  input  logic int_req,
`ifdef INT_MASK_EN
  input  logic int_mask,
`endif
  input  logic stall_in,
  output logic stall,
  output logic push,
  output logic pop,
  output logic push_src,
  output logic pop_dst,
  output logic second_iter,
  output logic flush,
  output logic int_ack,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALL_PUSH,
    S_RET_POP,
    S_RTI_POP_FLAGS,
    S_RTI_POP_PC,
    S_INT_PUSH_PC,
    S_INT_PUSH_FLAGS,
    S_FLUSH
  } state_t;

  localparam logic [1:0] LP_FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_int_pend;
  logic       r_int_seq;
  logic       r_live;
  logic       w_int_go;
  logic       w_start;
  logic       w_go;

`ifdef INT_MASK_EN
  assign w_int_go = r_int_pend & ~int_mask;
`else
  assign w_int_go = r_int_pend;
`endif

  // r_live keeps the first cycle after reset release quiet
  assign w_start = (r_state == S_IDLE) && r_live && !stall_in &&
                   (rti_req || ret_req || call_req || w_int_go);
  assign w_go    = !stall_in;
  assign busy    = (r_state != S_IDLE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_int_pend <= 1'b0;
      r_int_seq  <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (int_req) r_int_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_live && !stall_in) begin
            if (rti_req)       r_state <= S_RTI_POP_FLAGS;
            else if (ret_req)  r_state <= S_RET_POP;
            else if (call_req) r_state <= S_CALL_PUSH;
            else if (w_int_go) begin
              // a same-cycle int_req merges into the one being serviced
              r_state    <= S_INT_PUSH_PC;
              r_int_pend <= 1'b0;
              r_int_seq  <= 1'b1;
            end
          end
        end
        S_RTI_POP_FLAGS: if (w_go) r_state <= S_RTI_POP_PC;
        S_INT_PUSH_PC:   if (w_go) r_state <= S_INT_PUSH_FLAGS;
        S_CALL_PUSH, S_RET_POP, S_RTI_POP_PC, S_INT_PUSH_FLAGS: begin
          if (w_go) begin
            r_state <= S_FLUSH;
            r_cnt   <= LP_FLUSH_LOAD;
          end
        end
        S_FLUSH: begin
          if (w_go) begin
            if (r_cnt == 2'd0) begin
              r_state   <= S_IDLE;
              r_int_seq <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    push_src    = 1'b0;
    pop_dst     = 1'b0;
    second_iter = 1'b0;
    flush       = 1'b0;
    int_ack     = 1'b0;
    case (r_state)
      S_IDLE: stall = w_start;
      S_CALL_PUSH: begin
        stall = 1'b1; push = w_go; second_iter = w_go;
      end
      S_RET_POP: begin
        stall = 1'b1; pop = w_go; second_iter = w_go;
      end
      S_RTI_POP_FLAGS: begin
        stall = 1'b1; pop = w_go; pop_dst = 1'b1;
      end
      S_RTI_POP_PC: begin
        stall = 1'b1; pop = w_go; second_iter = w_go;
      end
      S_INT_PUSH_PC: begin
        stall = 1'b1; push = w_go;
      end
      S_INT_PUSH_FLAGS: begin
        stall = 1'b1; push = w_go; push_src = 1'b1; second_iter = w_go;
      end
      S_FLUSH: begin
        stall   = stall_in;
        flush   = w_go;
        int_ack = w_go && r_int_seq && (r_cnt == LP_FLUSH_LOAD);
      end
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Bench for stack_seq_ctrl: directed scenarios then random traffic, checked cycle by cycle
// against a model that expands each started operation into its list of per-cycle output steps.
module tb_stack_seq_ctrl;

  localparam int FC = 3;
`ifdef INT_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  // step vector: {stall,push,pop,push_src,pop_dst,second_iter,flush,int_ack}
  localparam logic [7:0] V_CALL = 8'b1100_0100;
  localparam logic [7:0] V_RET  = 8'b1010_0100;
  localparam logic [7:0] V_RPF  = 8'b1010_1000;
  localparam logic [7:0] V_RPC  = 8'b1010_0100;
  localparam logic [7:0] V_IPC  = 8'b1100_0000;
  localparam logic [7:0] V_IPF  = 8'b1101_0100;
  localparam logic [7:0] V_FL   = 8'b0000_0010;
  localparam logic [7:0] V_FLA  = 8'b0000_0011;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic call_req = 1'b0, ret_req = 1'b0, rti_req = 1'b0, int_req = 1'b0;
  logic stall_in = 1'b0, int_mask = 1'b0;
  logic stall, push, pop, push_src, pop_dst, second_iter, flush, int_ack, busy;

  int n_assert = 0;
  int n_fail   = 0;
  int n_cyc    = 0;
  string tag   = "init";

  logic [7:0] q[$];
  bit m_pend = 1'b0;
  bit m_live = 1'b0;

  always #5 Clk = ~Clk;

  stack_seq_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .Clk(Clk), .Rst(Rst),
    .call_req(call_req), .ret_req(ret_req), .rti_req(rti_req), .int_req(int_req),
`ifdef INT_MASK_EN
    .int_mask(int_mask),
`endif
    .stall_in(stall_in),
    .stall(stall), .push(push), .pop(pop), .push_src(push_src), .pop_dst(pop_dst),
    .second_iter(second_iter), .flush(flush), .int_ack(int_ack), .busy(busy)
  );

  function automatic logic [7:0] obs_vec();
    return {stall, push, pop, push_src, pop_dst, second_iter, flush, int_ack};
  endfunction

  task automatic add_seq(input logic [7:0] a, input logic [7:0] b, input bit two, input bit ack);
    q.push_back(a);
    if (two) q.push_back(b);
    for (int k = 0; k < FC; k++) q.push_back((ack && k == 0) ? V_FLA : V_FL);
  endtask

  // one clock cycle: drive, compare against model, advance model, step to next edge
  task automatic cyc(input logic c, input logic r, input logic t, input logic i,
                     input logic s, input logic m);
    logic [7:0] exp_v;
    logic [7:0] tmp;
    logic       exp_b;
    bit         np;
    call_req = c; ret_req = r; rti_req = t; int_req = i; stall_in = s;
    int_mask = m & MASK_ON;
    #3;
    if (q.size() == 0) begin
      exp_b = 1'b0;
      exp_v = {m_live && !s && (t || r || c || (m_pend && !int_mask)), 7'b0};
    end else begin
      exp_b = 1'b1;
      exp_v = q[0];
      if (s) exp_v = {1'b1, 2'b00, exp_v[4:3], 3'b000};
    end
    n_assert++;
    assert (obs_vec() === exp_v) else begin
      n_fail++;
      $error("FAIL %s cyc%0d outputs=%b expected=%b", tag, n_cyc, obs_vec(), exp_v);
    end
    n_assert++;
    assert (busy === exp_b) else begin
      n_fail++;
      $error("FAIL %s busy cyc%0d got=%b expected=%b", tag, n_cyc, busy, exp_b);
    end
    np = m_pend | i;
    if (q.size() != 0) begin
      if (!s) tmp = q.pop_front();
    end else if (m_live && !s) begin
      if (t)      add_seq(V_RPF, V_RPC, 1'b1, 1'b0);
      else if (r) add_seq(V_RET, V_RET, 1'b0, 1'b0);
      else if (c) add_seq(V_CALL, V_CALL, 1'b0, 1'b0);
      else if (m_pend && !int_mask) begin
        add_seq(V_IPC, V_IPF, 1'b1, 1'b1);
        np = 1'b0;
      end
    end
    m_pend = np;
    m_live = 1'b1;
    n_cyc++;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string t);
    n_assert++;
    assert ({obs_vec(), busy} === 9'd0) else begin
      n_fail++;
      $error("FAIL %s outputs+busy=%b expected=000000000", t, {obs_vec(), busy});
    end
  endtask

  initial begin
    // reset state
    tag = "reset";
    #2;
    check_zero("reset_hold");
    @(posedge Clk); #1;
    Rst = 1'b1;
    tag = "after_release";
    idle(2);

    tag = "call";
    cyc(1, 0, 0, 0, 0, 0);
    idle(FC + 3);

    tag = "rti";
    cyc(0, 0, 1, 0, 0, 0);
    idle(FC + 4);

    tag = "int";
    cyc(0, 0, 0, 1, 0, 0);
    idle(FC + 5);

    tag = "call_plus_int";
    cyc(1, 0, 0, 1, 0, 0);
    idle(2 * FC + 8);

    tag = "ret_stall";
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(FC + 3);

    tag = "flush_stall_int";
    cyc(0, 0, 0, 1, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 1, 0);
    idle(FC + 3);

    tag = "multi_req";
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle(FC + 4);

    // async reset in INT_PUSH_FLAGS
    tag = "mid_reset";
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    Rst = 1'b0;
    #1;
    check_zero("mid_reset_async");
    q.delete();
    m_pend = 1'b0;
    m_live = 1'b0;
    @(posedge Clk); #1;
    check_zero("mid_reset_hold");
    Rst = 1'b1;
    idle(FC + 4);

    tag = "mask";
    cyc(0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 1);
    idle(FC + 5);

    tag = "random";
    for (int k = 0; k < 1500; k++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 13) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
    end
    idle(2 * FC + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
